module_input_debounce: RTL and testbench
========================================

// Module: module_input_debounce
// PURPOSE
//  Input side of the board switch/button interface: conditions raw asynchronous
//  push buttons and slide switches into clean, clock-synchronous levels.
//  Also emits single-cycle press/release pulses per button.
//  Sits between board pins and the LED/display logic, which consume only its outputs.
// PARAMETERS
//  N_BTN         4        number of push buttons (active-high: 1 = pressed)
//  N_SW          16       number of slide switches
//  TICK_DIV      100000   clk cycles per sample tick (1 ms at 100 MHz); >= 2
//  STABLE_TICKS  10       consecutive mismatching ticks needed to accept a new level; >= 1
// PORTS
//  clk            in   1      system clock, single clock domain
//  rst_n          in   1      asynchronous, active-low reset
//  btn_i          in   N_BTN  raw push buttons, asynchronous to clk
//  sw_i           in   N_SW   raw switches, asynchronous to clk
//  btn_level_o    out  N_BTN  debounced button levels
//  btn_press_o    out  N_BTN  1-cycle pulse on debounced 0->1
//  btn_release_o  out  N_BTN  1-cycle pulse on debounced 1->0
//  sw_level_o     out  N_SW   debounced switch levels
// BEHAVIOUR
//  Reset (rst_n=0, async assert):
//   - all outputs 0; sync flops, stable regs, counters and tick prescaler cleared.
//   - synchronous release: first tick occurs TICK_DIV cycles after rst_n rises.
//  Tick generator:
//   - prescaler counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle at TICK_DIV-1.
//   - one tick is shared by all inputs.
//  Per input, uniform for buttons and switches:
//   - 2-FF synchronizer, reset 0 -> sync.
//   - stable register drives *_level_o; cnt is $clog2(STABLE_TICKS+1) bits.
//   - any cycle with sync==stable: cnt<=0. Mismatch between ticks does not count,
//     and a bounce back clears progress immediately.
//   - tick with sync!=stable and cnt==STABLE_TICKS-1: stable<=sync, cnt<=0.
//   - tick with sync!=stable otherwise: cnt<=cnt+1.
//   - Latency from a clean raw edge to level_o change: 2 sync cycles
//     + between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles.
//   - Glitches shorter than (STABLE_TICKS-1)*TICK_DIV cycles never reach level_o.
//  Pulses (buttons only):
//   - registered edge detect on stable: press=stable&~stable_q, release=~stable&stable_q.
//   - Pulses are high exactly one cycle, coincident with the first cycle of the new level.
//   - press and release are never both high for one bit.
//  Simultaneous events:
//   - inputs are fully independent; any number may change level on the same tick.
//  Reset mid-operation:
//   - in-progress qualification is discarded.
//   - after reset, an input held at 1 re-qualifies through the full latency and
//     then generates a press pulse.
//  Counters saturate by construction: reset at accept, never exceed STABLE_TICKS-1.
// STRUCTURE
//  - Package module_input_pkg:
//     default localparams (N_BTN, N_SW, TICK_DIV, STABLE_TICKS);
//     width helpers TICK_W=$clog2(TICK_DIV), CNT_W=$clog2(STABLE_TICKS+1).
//  - Sub-module module_debounce_cell:
//     1 input, 2-FF sync, cnt, stable, optional edge-detect outputs.
//     Instantiated N_BTN+N_SW times via generate.
//  - Prescaler and top-level wiring stay in this module.
// TESTING (bench overrides TICK_DIV=4, STABLE_TICKS=3)
//  1 Reset:
//    rst_n=0 with all raw inputs=1
//    -> all outputs 0 while in reset.
//    After release, btn_level_o=4'hF within 2+12 cycles and exactly one press pulse per button.
//  2 Clean press:
//    btn_i[0] 0->1, held
//    -> btn_level_o[0]=1 after 11..14 cycles; btn_press_o[0] high 1 cycle;
//       no other output changes.
//  3 Bounce reject:
//    btn_i[1] toggles 1 for 6 cycles, 0 for 2, repeated 5 times
//    -> btn_level_o[1] stays 0; no pulses.
//  4 Release:
//    after test 2, btn_i[0] 1->0
//    -> level drops after 11..14 cycles; btn_release_o[0] pulses once; btn_press_o[0] stays 0.
//  5 Simultaneous:
//    sw_i 16'h0000->16'hA5C3 and btn_i 4'h0->4'h9 on the same cycle
//    -> sw_level_o=16'hA5C3 and btn_level_o=4'h9 on the same cycle;
//       press pulses on bits 0 and 3 only.
//  6 Reset mid-qualify:
//    btn_i[2]=1, assert rst_n after 2 ticks, release 3 cycles later
//    -> level 0 through reset; full 11..14-cycle qualification restarts after release.

Source files
------------

// File: rtl/module_input_debounce_pkg.sv
// Shared defaults and width helpers for the board input debouncer.
// The defaults describe a 100 MHz board with a 1 ms sample tick.
// Instances normally override them.

package module_input_pkg;

    // Number of push buttons. Buttons are active-high (1 = pressed).
    localparam int N_BTN        = 4;
    // Number of slide switches.
    localparam int N_SW         = 16;
    // Clock cycles per sample tick. Must be at least 2.
    localparam int TICK_DIV     = 100000;
    // Consecutive mismatching ticks needed to accept a new level. Must be at least 1.
    localparam int STABLE_TICKS = 10;

    // Width of the tick prescaler, which counts 0..div-1.
    function automatic int tick_width(int div);
        return $clog2(div);
    endfunction

    // Width of the per-input qualification counter.
    function automatic int cnt_width(int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    localparam int TICK_W = tick_width(TICK_DIV);
    localparam int CNT_W  = cnt_width(STABLE_TICKS);

endpackage : module_input_pkg

// File: rtl/module_input_debounce_if.sv
// Pin-side bundle of the debouncer.
// The board side (master) drives the raw levels and consumes the clean ones.
// The debouncer (slave) does the reverse.

interface module_input_debounce_if #(
    parameter int N_BTN = module_input_pkg::N_BTN,
    parameter int N_SW  = module_input_pkg::N_SW
);

    // Raw pins. These are asynchronous to clk.
    logic [N_BTN-1:0] btn_i;
    logic [N_SW-1:0]  sw_i;

    // Debounced, clk-synchronous results.
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;
    logic [N_SW-1:0]  sw_level_o;

    modport master (
        output btn_i,
        output sw_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_release_o,
        input  sw_level_o
    );

    modport slave (
        input  btn_i,
        input  sw_i,
        output btn_level_o,
        output btn_press_o,
        output btn_release_o,
        output sw_level_o
    );

endinterface : module_input_debounce_if

// File: rtl/module_input_debounce_cell.sv
// Debounce cell for one raw input. It contains:
//  - a 2-FF synchronizer;
//  - a tick-qualified stability counter;
//  - the accepted (stable) level;
//  - optional press/release edge pulses.
// A new level is accepted only after STABLE_TICKS consecutive ticks of mismatch.
// Any cycle where the synchronized input agrees with the stable level clears
// the progress, so a bounce back always restarts qualification.

module module_debounce_cell #(
    parameter int STABLE_TICKS = module_input_pkg::STABLE_TICKS,
    parameter bit EDGE_EN      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    import module_input_pkg::*;

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_ff;
    logic          sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clk domain.
    // NOTE: sync_ff[0] may go metastable. Only sync_ff[1] is used by any logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
        end
    end

    assign sync = sync_ff[1];

    // Count the ticks that see a mismatch, and accept the new level on the last one.
    // The counter returns to zero on accept, so it never exceeds STABLE_TICKS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level_o = stable;

    generate
        if (EDGE_EN) begin : g_edge
            logic stable_q;

            // Delay the stable level by one cycle for edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_q <= 1'b0;
                end else begin
                    stable_q <= stable;
                end
            end

            // Both terms come straight from flops.
            // Each pulse lines up with the first cycle of the new level.
            // A bit can never pulse press and release together.
            assign press_o   = stable & ~stable_q;
            assign release_o = ~stable & stable_q;
        end else begin : g_no_edge
            assign press_o   = 1'b0;
            assign release_o = 1'b0;
        end
    endgenerate

endmodule : module_debounce_cell

// File: rtl/module_input_debounce.sv
// Board switch/button conditioner.
// One shared prescaler produces the sample tick. Every button and switch
// gets its own debounce cell. Buttons also produce press/release pulses.
// Downstream LED/display logic sees only these clean, synchronous outputs.

module module_input_debounce #(
    parameter int N_BTN        = module_input_pkg::N_BTN,
    parameter int N_SW         = module_input_pkg::N_SW,
    parameter int TICK_DIV     = module_input_pkg::TICK_DIV,
    parameter int STABLE_TICKS = module_input_pkg::STABLE_TICKS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    module_input_debounce_if.slave  bus
);

    import module_input_pkg::*;

    localparam int               PRE_W    = tick_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescale;
    logic             tick;

    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_press_unused;
    logic [N_SW-1:0]  sw_release_unused;

    // Free-running prescaler, 0..TICK_DIV-1.
    // It starts from 0 after reset, so the first tick comes TICK_DIV cycles
    // after rst_n rises.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop in the design samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    // One-cycle tick in the last prescaler state. All cells share it.
    assign tick = (prescale == PRE_LAST);

    // Buttons use the full cell, including the edge pulses.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        module_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .EDGE_EN      (1'b1)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .raw       (bus.btn_i[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i])
        );
    end

    // Switches only need the level. The edge logic is not built for them.
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        module_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .EDGE_EN      (1'b0)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .raw       (bus.sw_i[i]),
            .level_o   (sw_level[i]),
            .press_o   (sw_press_unused[i]),
            .release_o (sw_release_unused[i])
        );
    end

    assign bus.btn_level_o   = btn_level;
    assign bus.btn_press_o   = btn_press;
    assign bus.btn_release_o = btn_release;
    assign bus.sw_level_o    = sw_level;

endmodule : module_input_debounce

// File: tb/tb_module_input_debounce.sv
// Directed bench for module_input_debounce, using TICK_DIV=4 and STABLE_TICKS=3.
// An edge-indexed reference model predicts every output on every cycle.
// Directed checks pin the model to hand-computed latencies and pulse counts.

module tb_module_input_debounce;

    localparam int N_BTN = 4;
    localparam int N_SW  = 16;
    localparam int TD    = 4;
    localparam int ST    = 3;
    localparam int N     = N_BTN + N_SW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    module_input_debounce_if #(.N_BTN(N_BTN), .N_SW(N_SW)) bus ();

    module_input_debounce #(
        .N_BTN        (N_BTN),
        .N_SW         (N_SW),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model.
    // Edges are numbered from rst_n release: edge e is a tick edge iff e % TD == 0.
    // The level the cell compares at edge e is the raw pin sampled at edge e-2.
    // A run of disagreement that starts at edge s is accepted at the first
    // tick edge e where the number of tick edges in [s, e] reaches ST.
    // ------------------------------------------------------------------
    logic [N-1:0] m_level, m_press, m_rel, m_h1, m_h2;
    int           m_start [N];
    int           m_edge;

    function automatic int ticks_in(input int first, input int last);
        return last / TD - (first - 1) / TD;
    endfunction

    task automatic model_reset();
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_h1    = '0;
        m_h2    = '0;
        m_edge  = 0;
        for (int i = 0; i < N; i++) m_start[i] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] seen, prev;
        m_edge++;
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = {bus.sw_i, bus.btn_i};
        prev = m_level;
        for (int i = 0; i < N; i++) begin
            if (seen[i] == m_level[i]) begin
                m_start[i] = 0;
            end else begin
                if (m_start[i] == 0) m_start[i] = m_edge;
                if ((m_edge % TD) == 0 && ticks_in(m_start[i], m_edge) >= ST) begin
                    m_level[i] = seen[i];
                    m_start[i] = 0;
                end
            end
        end
        m_press = m_level & ~prev;
        m_rel   = ~m_level & prev;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // Compare every DUT output with the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_vs_dut",
                  {4'h0, bus.btn_level_o, bus.btn_press_o, bus.btn_release_o, bus.sw_level_o},
                  {4'h0, m_level[N_BTN-1:0], m_press[N_BTN-1:0], m_rel[N_BTN-1:0], m_level[N-1:N_BTN]});
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int press_cnt [N_BTN];
    int rel_cnt   [N_BTN];

    task automatic clear_counts();
        for (int i = 0; i < N_BTN; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
    endtask

    // Advance one cycle, then accumulate the pulses seen in it.
    task automatic tick_obs();
        @(negedge clk);
        for (int i = 0; i < N_BTN; i++) begin
            press_cnt[i] += int'(bus.btn_press_o[i]);
            rel_cnt[i]   += int'(bus.btn_release_o[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick_obs();
    endtask

    // Cycles until a button bit reaches val. The wait is bounded at 40 cycles.
    task automatic wait_btn(input int b, input logic val, output int cyc);
        cyc = 0;
        while (bus.btn_level_o[b] !== val && cyc < 40) begin
            tick_obs();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        clear_counts();

        // 1: reset with every raw input high.
        bus.btn_i = '1;
        bus.sw_i  = '1;
        idle(3);
        check("rst_btn_level",   {28'h0, bus.btn_level_o},   32'h0);
        check("rst_btn_press",   {28'h0, bus.btn_press_o},   32'h0);
        check("rst_btn_release", {28'h0, bus.btn_release_o}, 32'h0);
        check("rst_sw_level",    {16'h0, bus.sw_level_o},    32'h0);
        clear_counts();
        rst_n = 1'b1;
        cyc = 0;
        while (bus.btn_level_o !== 4'hF && cyc < 40) begin
            tick_obs();
            cyc++;
        end
        // The sync is valid before edge 3, and the ticks fall on edges 4, 8 and 12.
        check("rst_release_latency", cyc, 12);
        check("rst_sw_level_after", {16'h0, bus.sw_level_o}, 32'h0000_FFFF);
        idle(5);
        for (int i = 0; i < N_BTN; i++) begin
            check($sformatf("rst_press_count_%0d", i), press_cnt[i], 1);
            check($sformatf("rst_release_count_%0d", i), rel_cnt[i], 0);
        end
        bus.btn_i = '0;
        bus.sw_i  = '0;
        idle(20);
        check("settle_all_low", {8'h0, bus.btn_level_o, bus.sw_level_o}, 32'h0);

        // 2: clean press of button 0.
        clear_counts();
        bus.btn_i[0] = 1'b1;
        wait_btn(0, 1'b1, cyc);
        check_range("press_latency", cyc, 11, 14);
        check("press_pulse_coincident", {28'h0, bus.btn_press_o}, 32'h1);
        tick_obs();
        check("press_pulse_one_cycle", {28'h0, bus.btn_press_o}, 32'h0);
        idle(5);
        check("press_count", press_cnt[0], 1);
        check("press_others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[0], 0);
        check("press_levels", {8'h0, bus.btn_level_o, bus.sw_level_o}, 32'h0001_0000);

        // 3: button 1 bounces: 6 cycles high, then 2 low, five times.
        clear_counts();
        for (int r = 0; r < 5; r++) begin
            bus.btn_i[1] = 1'b1;
            idle(6);
            bus.btn_i[1] = 1'b0;
            idle(2);
        end
        idle(4);
        check("bounce_level", {31'h0, bus.btn_level_o[1]}, 32'h0);
        check("bounce_pulses", press_cnt[1] + rel_cnt[1], 0);

        // 4: release button 0.
        clear_counts();
        bus.btn_i[0] = 1'b0;
        wait_btn(0, 1'b0, cyc);
        check_range("release_latency", cyc, 11, 14);
        check("release_pulse_coincident", {28'h0, bus.btn_release_o}, 32'h1);
        idle(5);
        check("release_count", rel_cnt[0], 1);
        check("release_no_press", press_cnt[0], 0);

        // 5: switches and buttons change on the same cycle.
        clear_counts();
        bus.sw_i  = 16'hA5C3;
        bus.btn_i = 4'h9;
        cyc = 0;
        while (bus.btn_level_o === 4'h0 && cyc < 40) begin
            tick_obs();
            cyc++;
        end
        check_range("simul_latency", cyc, 11, 14);
        check("simul_btn_level", {28'h0, bus.btn_level_o}, 32'h9);
        check("simul_sw_level", {16'h0, bus.sw_level_o}, 32'h0000_A5C3);
        check("simul_press", {28'h0, bus.btn_press_o}, 32'h9);
        idle(3);
        check("simul_press_counts", {press_cnt[3][7:0], press_cnt[2][7:0], press_cnt[1][7:0], press_cnt[0][7:0]},
              32'h0100_0001);

        // 6: a reset during qualification discards the progress.
        bus.sw_i  = '0;
        bus.btn_i = '0;
        idle(20);
        clear_counts();
        bus.btn_i[2] = 1'b1;
        idle(8);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_obs();
            check($sformatf("midrst_level_%0d", k), {8'h0, bus.btn_level_o, bus.sw_level_o}, 32'h0);
        end
        rst_n = 1'b1;
        wait_btn(2, 1'b1, cyc);
        check("midrst_requalify_latency", cyc, 12);
        idle(4);
        check("midrst_press_count", press_cnt[2], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_module_input_debounce
